// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED display scheduler and its SPI ownership mux.
package oled_pkg;

    typedef logic [9:0] spi_word_t;
    typedef logic [2:0] state_t;

    localparam state_t StRstLo   = 3'd0;
    localparam state_t StRstWt   = 3'd1;
    localparam state_t StInit    = 3'd2;
    localparam state_t StDraw    = 3'd3;
    localparam state_t StRefresh = 3'd4;
    localparam state_t StHold    = 3'd5;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnInit = 2'd1,
        OwnWr   = 2'd2
    } owner_e;

    // Word prefix in bits[9:8]: 00 command, 01 data, 11 idle
    localparam logic [1:0] SPI_CMD       = 2'b00;
    localparam logic [1:0] SPI_DAT       = 2'b01;
    localparam spi_word_t  SPI_IDLE_WORD = 10'h300;

endpackage

// File: rtl/oled_disp_ctrl_if.sv
// Start/done handshake bus to the shared SPI byte-writer.
interface oled_disp_ctrl_if;
    import oled_pkg::*;

    logic      spi_write_start;
    spi_word_t spi_data;
    logic      spi_write_done;

    modport master (output spi_write_start, output spi_data, input spi_write_done);
    modport slave  (input spi_write_start, input spi_data, output spi_write_done);
endinterface

// File: rtl/oled_spi_mux.sv
// Steers the SPI writer between the init requester and the frame writer by registered owner.
module oled_spi_mux
    import oled_pkg::*;
(
    input  owner_e    owner_i,
    input  logic      init_spi_start_i,
    input  spi_word_t init_spi_data_i,
    input  logic      wr_spi_start_i,
    input  spi_word_t wr_spi_data_i,
    input  logic      spi_write_done_i,
    output logic      spi_write_start_o,
    output spi_word_t spi_data_o,
    output logic      init_spi_done_o,
    output logic      wr_spi_done_o
);

    always_comb begin
        spi_write_start_o = 1'b0;
        spi_data_o        = SPI_IDLE_WORD;
        case (owner_i)
            OwnInit: begin
                spi_write_start_o = init_spi_start_i;
                spi_data_o        = init_spi_data_i;
            end
            OwnWr: begin
                spi_write_start_o = wr_spi_start_i;
                spi_data_o        = wr_spi_data_i;
            end
            default: ;
        endcase
        init_spi_done_o = spi_write_done_i & (owner_i == OwnInit);
        wr_spi_done_o   = spi_write_done_i & (owner_i == OwnWr);
    end

endmodule

// File: rtl/oled_disp_ctrl.sv
// OLED path scheduler: panel reset, init sequence, then periodic or on-demand frame redraws,
// with a shared delay/watchdog counter and exclusive ownership of the SPI writer.
module oled_disp_ctrl
    import oled_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC  = 10,
    parameter int unsigned RST_WAIT_CYC = 100,
    parameter int unsigned REFRESH_CYC  = 50000,
    parameter int unsigned TIMEOUT_CYC  = 200000,
    parameter int unsigned CNT_W        = 18
) (
    input  logic      clk_1m,
    input  logic      rst_n,
    input  logic      refresh_en,
    input  logic      refresh_req,
    output logic      oled_res_n,
    output logic      init_start,
    input  logic      init_done,
    input  logic      init_spi_start,
    input  spi_word_t init_spi_data,
    output logic      init_spi_done,
    output logic      wr_start,
    input  logic      wr_done,
    input  logic      wr_spi_start,
    input  spi_word_t wr_spi_data,
    output logic      wr_spi_done,
    oled_disp_ctrl_if.master spi,
    output logic      frame_done,
    output logic      busy,
    output logic      err
);

    localparam logic [CNT_W-1:0] LowLast  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] RefLast  = CNT_W'(REFRESH_CYC - 1);
    localparam logic [CNT_W-1:0] ToLast   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    logic             err_q, err_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        case (state_q)
            StRstLo: if (cnt_q == LowLast) state_d = StRstWt;
            StRstWt: if (cnt_q == WaitLast) state_d = StInit;
            StInit: begin
                // A done arriving on the timeout cycle still counts as success
                if (init_done) begin
                    state_d = StDraw;
                end else if (cnt_q == ToLast) begin
                    state_d = StRstLo;
                    err_d   = 1'b1;
                end
            end
            StDraw: begin
                if (wr_done) begin
                    frame_done_d = 1'b1;
                    state_d      = refresh_en ? StRefresh : StHold;
                end else if (cnt_q == ToLast) begin
                    state_d = StRstLo;
                    err_d   = 1'b1;
                end
            end
            StRefresh: begin
                if (!refresh_en)          state_d = StHold;
                else if (cnt_q == RefLast) state_d = StDraw;
            end
            StHold:  if (refresh_req) state_d = StDraw;
            default: state_d = StRstLo;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CntOne;

        // Entering DRAW straight from INIT leaves one ownerless cycle so a stale init start
        // can never be forwarded as a frame-writer word.
        owner_d = OwnNone;
        if (state_d == StInit) begin
            owner_d = OwnInit;
        end else if (state_d == StDraw && state_q != StInit) begin
            owner_d = OwnWr;
        end
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRstLo;
            cnt_q        <= '0;
            owner_q      <= OwnNone;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign oled_res_n = (state_q != StRstLo);
    assign init_start = (state_q == StInit);
    assign wr_start   = (state_q == StDraw);
    assign busy       = (state_q != StRefresh) && (state_q != StHold);
    assign err        = err_q;
    assign frame_done = frame_done_q;

    oled_spi_mux u_spi_mux (
        .owner_i           (owner_q),
        .init_spi_start_i  (init_spi_start),
        .init_spi_data_i   (init_spi_data),
        .wr_spi_start_i    (wr_spi_start),
        .wr_spi_data_i     (wr_spi_data),
        .spi_write_done_i  (spi.spi_write_done),
        .spi_write_start_o (spi.spi_write_start),
        .spi_data_o        (spi.spi_data),
        .init_spi_done_o   (init_spi_done),
        .wr_spi_done_o     (wr_spi_done)
    );

endmodule

// File: tb/tb_oled_disp_ctrl.sv
// Scoreboard bench for oled_disp_ctrl with shortened refresh and watchdog periods.
module tb_oled_disp_ctrl;
    import oled_pkg::*;

    localparam int RstLow  = 10;
    localparam int RstWait = 100;
    localparam int Refresh = 500;
    localparam int Timeout = 2000;

    logic      clk_1m = 1'b0;
    logic      rst_n = 1'b0;
    logic      refresh_en = 1'b0;
    logic      refresh_req = 1'b0;
    logic      init_done = 1'b0;
    logic      init_spi_start = 1'b0;
    spi_word_t init_spi_data = '0;
    logic      wr_done = 1'b0;
    logic      wr_spi_start = 1'b0;
    spi_word_t wr_spi_data = '0;
    logic      oled_res_n, init_start, init_spi_done, wr_start, wr_spi_done;
    logic      frame_done, busy, err;

    oled_disp_ctrl_if spi_bus ();

    oled_disp_ctrl #(
        .RST_LOW_CYC  (RstLow),
        .RST_WAIT_CYC (RstWait),
        .REFRESH_CYC  (Refresh),
        .TIMEOUT_CYC  (Timeout),
        .CNT_W        (18)
    ) dut (
        .clk_1m         (clk_1m),
        .rst_n          (rst_n),
        .refresh_en     (refresh_en),
        .refresh_req    (refresh_req),
        .oled_res_n     (oled_res_n),
        .init_start     (init_start),
        .init_done      (init_done),
        .init_spi_start (init_spi_start),
        .init_spi_data  (init_spi_data),
        .init_spi_done  (init_spi_done),
        .wr_start       (wr_start),
        .wr_done        (wr_done),
        .wr_spi_start   (wr_spi_start),
        .wr_spi_data    (wr_spi_data),
        .wr_spi_done    (wr_spi_done),
        .spi            (spi_bus),
        .frame_done     (frame_done),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk_1m = ~clk_1m;

    int        n_checks = 0;
    int        n_fail = 0;
    int        n_words = 0;
    bit        mon_en = 1'b1;
    spi_word_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_outs"}, 32'({oled_res_n, init_start, wr_start, frame_done, err, busy,
                 spi_bus.spi_write_start, init_spi_done, wr_spi_done}), 32'b000001000);
        check_eq({tag, "_spi_data"}, 32'(spi_bus.spi_data), 32'(SPI_IDLE_WORD));
    endtask

    // Every start reaching the SPI writer must match the oldest expected word.
    always @(posedge clk_1m) begin
        #1;
        if (mon_en && spi_bus.spi_write_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spi_unexpected_start", 32'(spi_bus.spi_write_start), 32'd0);
            end else begin
                check_eq("spi_word", 32'(spi_bus.spi_data), 32'(exp_q.pop_front()));
                n_words++;
            end
        end
    end

    // Owner issues word w while the other requester fires a junk start alongside.
    task automatic send_word(input bit to_wr, input spi_word_t w);
        @(negedge clk_1m);
        init_spi_start = 1'b1;
        wr_spi_start   = 1'b1;
        init_spi_data  = to_wr ? 10'h0E7 : w;
        wr_spi_data    = to_wr ? w : 10'h1A5;
        exp_q.push_back(w);
        @(negedge clk_1m);
        init_spi_start = 1'b0;
        wr_spi_start   = 1'b0;
        spi_bus.spi_write_done = 1'b1;
        #1;
        check_eq(to_wr ? "wr_done_routed" : "init_done_routed",
                 32'(to_wr ? wr_spi_done : init_spi_done), 32'd1);
        check_eq(to_wr ? "init_done_blocked" : "wr_done_blocked",
                 32'(to_wr ? init_spi_done : wr_spi_done), 32'd0);
        @(negedge clk_1m);
        spi_bus.spi_write_done = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        spi_bus.spi_write_done = 1'b0;
        refresh_en = 1'b1;
        #23;
        check_reset_vals("powerup_reset");

        // Panel reset timing
        @(negedge clk_1m);
        rst_n = 1'b1;
        ok = 1'b1;
        n  = 0;
        do begin
            @(negedge clk_1m);
            n++;
            if (spi_bus.spi_data !== SPI_IDLE_WORD) ok = 1'b0;
        end while (!oled_res_n && n < 1000);
        check_eq("res_low_cycles", n, RstLow);
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
            if (!oled_res_n) ok = 1'b0;
            if (!init_start && spi_bus.spi_data !== SPI_IDLE_WORD) ok = 1'b0;
        end while (!init_start && n < 1000);
        check_eq("res_high_cycles", n, RstWait);
        check_eq("powerup_idle_and_res_high", 32'(ok), 32'd1);

        // Init routing
        send_word(1'b0, 10'h0AE);
        send_word(1'b0, 10'h0D5);
        send_word(1'b0, 10'h080);
        check_eq("init_words_seen", n_words, 3);
        check_eq("init_scoreboard_empty", exp_q.size(), 0);
        @(negedge clk_1m);
        init_done = 1'b1;
        @(negedge clk_1m);
        init_done = 1'b0;
        check_eq("init_start_dropped", 32'(init_start), 32'd0);
        check_eq("wr_start_after_init", 32'(wr_start), 32'd1);
        wr_spi_start = 1'b1;
        wr_spi_data  = 10'h1A5;
        #1;
        check_eq("gap_start_blocked", 32'(spi_bus.spi_write_start), 32'd0);
        check_eq("gap_idle_word", 32'(spi_bus.spi_data), 32'(SPI_IDLE_WORD));
        wr_spi_start = 1'b0;
        send_word(1'b1, 10'h1FF);
        check_eq("wr_words_seen", n_words, 4);

        // Auto refresh
        @(negedge clk_1m);
        wr_done = 1'b1;
        @(negedge clk_1m);
        wr_done = 1'b0;
        check_eq("frame_wr_start_low", 32'(wr_start), 32'd0);
        check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
        check_eq("refresh_not_busy", 32'(busy), 32'd0);
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
            if (n == 1) check_eq("frame_done_one_cycle", 32'(frame_done), 32'd0);
        end while (!wr_start && n < 5000);
        check_eq("refresh_period", n, Refresh);

        // refresh_en falling mid-count parks in HOLD
        @(negedge clk_1m);
        wr_done = 1'b1;
        @(negedge clk_1m);
        wr_done = 1'b0;
        repeat (10) @(negedge clk_1m);
        refresh_en = 1'b0;
        ok = 1'b1;
        repeat (Refresh + 20) begin
            @(negedge clk_1m);
            if (wr_start !== 1'b0) ok = 1'b0;
        end
        check_eq("refresh_cancelled", 32'(ok), 32'd1);
        check_eq("hold_not_busy", 32'(busy), 32'd0);

        // Manual redraw from HOLD
        repeat (1000) @(negedge clk_1m);
        check_eq("hold_idle_wr_start", 32'(wr_start), 32'd0);
        refresh_req = 1'b1;
        @(negedge clk_1m);
        refresh_req = 1'b0;
        check_eq("req_starts_draw", 32'(wr_start), 32'd1);
        check_eq("draw_busy", 32'(busy), 32'd1);

        // wr_done on the watchdog limit cycle; refresh_req in DRAW is dropped
        for (int i = 1; i < Timeout; i++) begin
            @(negedge clk_1m);
            refresh_req = (i == 5);
        end
        refresh_req = 1'b0;
        wr_done = 1'b1;
        @(negedge clk_1m);
        wr_done = 1'b0;
        check_eq("tie_frame_done", 32'(frame_done), 32'd1);
        check_eq("tie_no_err", 32'(err), 32'd0);
        check_eq("tie_res_high", 32'(oled_res_n), 32'd1);
        check_eq("tie_to_hold", 32'({busy, wr_start}), 32'd0);
        repeat (20) @(negedge clk_1m);
        check_eq("req_not_queued", 32'(wr_start), 32'd0);

        // DRAW watchdog
        refresh_req = 1'b1;
        @(negedge clk_1m);
        refresh_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
        end while (!err && n < Timeout + 100);
        check_eq("draw_watchdog_cycles", n, Timeout);
        check_eq("draw_wd_res_low", 32'(oled_res_n), 32'd0);
        check_eq("draw_wd_starts_low", 32'({wr_start, init_start}), 32'd0);

        // Restart sequence keeps err
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
        end while (!oled_res_n && n < 1000);
        check_eq("restart_low_cycles", n, RstLow);
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
        end while (!init_start && n < 1000);
        check_eq("restart_high_cycles", n, RstWait);
        check_eq("err_sticky_restart", 32'(err), 32'd1);

        // INIT watchdog: init_done never arrives
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
        end while (init_start && n < Timeout + 100);
        check_eq("init_watchdog_cycles", n, Timeout);
        check_eq("init_wd_res_low", 32'(oled_res_n), 32'd0);
        check_eq("err_sticky_init_wd", 32'(err), 32'd1);

        // Asynchronous reset in DRAW with the frame writer owning the SPI writer
        n = 0;
        do begin
            @(negedge clk_1m);
            n++;
        end while (!init_start && n < 1000);
        init_done = 1'b1;
        @(negedge clk_1m);
        init_done = 1'b0;
        @(negedge clk_1m);
        mon_en = 1'b0;
        wr_spi_start = 1'b1;
        wr_spi_data  = 10'h1C3;
        spi_bus.spi_write_done = 1'b1;
        #1;
        check_eq("wr_owner_start", 32'(spi_bus.spi_write_start), 32'd1);
        check_eq("wr_owner_data", 32'(spi_bus.spi_data), 32'h1C3);
        @(posedge clk_1m);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midframe_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/oled_disp_ctrl.md
Name: oled_disp_ctrl

Overview:
- Top-level scheduler for the SSD1306-class OLED path.
- Sequences the panel hardware reset, then the init-command requester, then periodic frame redraws by the frame-writer requester.
- Owns the single shared SPI byte-writer: only the requester of the current phase may drive it.
- Sits between the init ROM sequencer, the frame writer (write_data_start / write_done handshake) and the SPI writer (10-bit words, start/done handshake).

Parameters:
- RST_LOW_CYC, 10: clk_1m cycles that oled_res_n is held low (10 us).
- RST_WAIT_CYC, 100: cycles waited after oled_res_n rises, before init.
- REFRESH_CYC, 50000: cycles from frame_done to the next auto-redraw (50 ms).
- TIMEOUT_CYC, 200000: watchdog limit for the INIT or DRAW phase.
- CNT_W, 18: width of the shared delay/watchdog counter; must hold the largest of the parameters above.

Ports:
- clk_1m  in  1  system clock, 1 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- refresh_en  in  1  1 = auto-redraw every REFRESH_CYC; 0 = redraw only on refresh_req.
- refresh_req  in  1  single-cycle redraw request; honoured in state HOLD.
- oled_res_n  out  1  panel reset pin.
- init_start  out  1  level; runs the init requester.
- init_done  in  1  single-cycle pulse from the init requester.
- init_spi_start  in  1  init requester's SPI start.
- init_spi_data  in  10  init requester's SPI word.
- init_spi_done  out  1  SPI done, routed to the init requester.
- wr_start  out  1  level; drives the frame writer's write_data_start.
- wr_done  in  1  frame writer's write_done pulse.
- wr_spi_start  in  1  frame writer's SPI start.
- wr_spi_data  in  10  frame writer's SPI word.
- wr_spi_done  out  1  SPI done, routed to the frame writer.
- spi_write_start  out  1  to the SPI writer.
- spi_data  out  10  to the SPI writer.
- spi_write_done  in  1  from the SPI writer.
- frame_done  out  1  one-cycle pulse per completed frame.
- busy  out  1  high in every state except HOLD and REFRESH.
- err  out  1  sticky watchdog flag; cleared only by rst_n.

Behaviour:
- Reset and clocking: rst_n asynchronous, active-low; clock clk_1m. All state is on posedge clk_1m.
- Reset values:
  - oled_res_n=0, init_start=0, wr_start=0, frame_done=0, err=0, busy=1.
  - spi_write_start=0, spi_data=10'h300 (idle word).
  - state=RST_LO, counter=0, owner=NONE.
- States:
  - RST_LO: oled_res_n=0. After RST_LOW_CYC cycles -> RST_WT.
  - RST_WT: oled_res_n=1. After RST_WAIT_CYC cycles -> INIT.
  - INIT: owner=INIT, init_start=1. On init_done -> DRAW; init_start drops on that same edge.
  - DRAW: owner=WR, wr_start=1. On wr_done:
    - wr_start drops on that same edge;
    - frame_done pulses 1 cycle;
    - next state is REFRESH if refresh_en=1, else HOLD.
  - REFRESH: count REFRESH_CYC cycles -> DRAW. If refresh_en falls during the count -> HOLD.
  - HOLD: refresh_req=1 -> DRAW.
- Watchdog:
  - The counter restarts at 0 on every state entry.
  - In INIT or DRAW, reaching TIMEOUT_CYC-1 sets err=1, drops all starts, and goes -> RST_LO to re-run the full sequence.
- SPI ownership mux:
  - owner is registered and is set on state entry.
  - spi_write_start and spi_data are combinational from the owner's inputs.
  - With owner=NONE: spi_write_start=0, spi_data=10'h300.
  - Done routing: init_spi_done = spi_write_done & owner==INIT; wr_spi_done = spi_write_done & owner==WR.
  - The non-owner's start is ignored and its done is held 0.
- Phase exit: owner goes to NONE for one cycle between INIT and DRAW, and whenever DRAW exits. This guarantees a stale start never reaches the SPI writer.
- Simultaneous events:
  - A done pulse and the watchdog limit in the same cycle: done wins, no error.
  - refresh_req outside HOLD is ignored, not queued.
- Word encoding (unchanged, passed through): bits[9:8] 00=command, 01=data, 11=idle.

Decomposition:
- Package oled_pkg holds:
  - state enum {RST_LO, RST_WT, INIT, DRAW, REFRESH, HOLD};
  - owner enum {NONE, INIT, WR};
  - SPI_CMD=2'b00, SPI_DAT=2'b01, SPI_IDLE_WORD=10'h300.
- One sub-module, oled_spi_mux: owner select plus start/data/done steering, purely combinational. The FSM and counter stay in oled_disp_ctrl.

Test Plan:
- Power-up:
  - stimulus: release rst_n.
  - required: oled_res_n low exactly 10 cycles, high 100 cycles, then init_start=1.
  - required: spi_data=10'h300 throughout.
- Init routing:
  - stimulus: init model issues 3 words (10'h0AE, 10'h0D5, 10'h080) with done pulses.
  - required: words appear on spi_data; only init_spi_done pulses.
  - required: wr_spi_start=1 injected meanwhile never reaches spi_write_start.
- Frame loop, refresh_en=1:
  - stimulus: wr_done pulse.
  - required: wr_start low on the next edge; frame_done one pulse.
  - required: wr_start high again exactly 50000 cycles later.
- Hold mode, refresh_en=0:
  - required: after frame, state HOLD, busy=0.
  - stimulus: refresh_req at cycle 1000 -> required: wr_start=1 on the next edge.
- Watchdog:
  - stimulus: init model never pulses init_done.
  - required: at 200000 cycles err=1 and oled_res_n=0.
  - required: the sequence restarts; err stays 1.
- Mid-frame reset:
  - stimulus: assert rst_n low during DRAW.
  - required: all outputs return to their reset values asynchronously, without waiting for a clock edge.
